// File: rtl/cpu_pkg.sv
// cpu_pkg: shared flag and condition-code types for the CPU pipeline
package cpu_pkg;
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;
  typedef enum logic [3:0] {
    EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
endpackage

// File: rtl/ex_mem_flag_stage_cond_eval.sv
// cond_eval: combinational ARM condition check, (cond, flags) -> cond_true
module cond_eval
  import cpu_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   cond_true
);
  always_comb begin
    cond_true = 1'b1;
    case (cond)
      EQ: cond_true = flags.z;
      NE: cond_true = !flags.z;
      HS: cond_true = flags.c;
      LO: cond_true = !flags.c;
      MI: cond_true = flags.n;
      PL: cond_true = !flags.n;
      VS: cond_true = flags.v;
      VC: cond_true = !flags.v;
      HI: cond_true = flags.c & !flags.z;
      LS: cond_true = !flags.c | flags.z;
      GE: cond_true = flags.n == flags.v;
      LT: cond_true = flags.n != flags.v;
      GT: cond_true = !flags.z & (flags.n == flags.v);
      LE: cond_true = flags.z | (flags.n != flags.v);
      default: cond_true = 1'b1;
    endcase
  end
endmodule

// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage: EX/MEM pipeline register, NZVC flag register with EX forwarding, and B.cond resolution
module ex_mem_flag_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [3:0]        ex_flags,
  input  logic              ex_set_flags,
  input  logic              ex_cond_branch,
  input  logic [3:0]        ex_cond,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [3:0]        flags_q,
  output logic [3:0]        flags_fwd,
  output logic              branch_taken
);
  logic kill;
  logic flag_we;
  logic cond_true;
  assign kill = flush | !ex_valid;
  assign flag_we = ex_valid & ex_set_flags & !stall & !flush;
  assign flags_fwd = (ex_valid & ex_set_flags) ? ex_flags : flags_q;
  assign branch_taken = ex_valid & ex_cond_branch & cond_true & !flush;
  cond_eval u_cond_eval (
    .cond      (cond_e'(ex_cond)),
    .flags     (flags_t'(flags_fwd)),
    .cond_true (cond_true)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_store_data <= '0;
    end else if (!stall) begin
      mem_valid      <= !kill;
      mem_result     <= ex_valid ? ex_result : '0;
      mem_rd         <= ex_valid ? ex_rd : '0;
      mem_reg_write  <= !kill & ex_reg_write;
      mem_mem_read   <= !kill & ex_mem_read;
      mem_mem_write  <= !kill & ex_mem_write;
      mem_store_data <= ex_valid ? ex_store_data : '0;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) flags_q <= '0;
    else if (flag_we) flags_q <= ex_flags;
endmodule
